// File: rtl/sprite_line_drawer.sv
// Sprite line drawer: fetches the sprite row crossing the current line from a 1-cycle-latency ROM
// into a row buffer, then replays it when the beam reaches the sprite. Option macro: SPRITE_TRANSPARENT_EN.
module sprite_line_drawer #(
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8,
  parameter int COLR_BITS  = 4,
  parameter int CORDW      = 16,
  localparam int ADDRW     = $clog2(SPR_WIDTH * SPR_HEIGHT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] spr_x,
  input  logic signed [CORDW-1:0] spr_y,
  output logic [ADDRW-1:0]        rom_addr,
  input  logic [COLR_BITS-1:0]    rom_data,
  output logic [COLR_BITS-1:0]    pix,
  output logic                    drawing,
  output logic                    busy
);

  localparam int IDXW = $clog2(SPR_WIDTH);
  localparam int CNTW = $clog2(SPR_WIDTH + 1);

  localparam logic signed [CORDW:0] ROW_LIM = (CORDW + 1)'(SPR_HEIGHT);
  localparam logic signed [CORDW:0] COL_LIM = (CORDW + 1)'(SPR_WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST       = CNTW'(SPR_WIDTH);
  localparam logic [CNTW-1:0] CNT_ISSUE_LAST = CNTW'(SPR_WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_LAST       = IDXW'(SPR_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REG_POS, FETCH, WAIT_POS, DRAW} state_t;

  state_t                  state_reg, state_next;
  logic signed [CORDW-1:0] spr_x_reg, spr_x_next;
  logic signed [CORDW-1:0] spr_y_reg, spr_y_next;
  logic [ADDRW-1:0]        rom_addr_reg, rom_addr_next;
  logic [CNTW-1:0]         cnt_reg, cnt_next;
  logic [IDXW-1:0]         index_reg, index_next;
  logic [COLR_BITS-1:0]    pix_reg, pix_next;
  logic                    drawing_reg, drawing_next;

  logic [COLR_BITS-1:0]    row_buf [SPR_WIDTH];
  logic                    cap_en;
  logic [IDXW-1:0]         cap_idx;
  logic [IDXW-1:0]         rd_idx;
  logic [COLR_BITS-1:0]    rd_pix;
  logic                    emit;

  logic signed [CORDW:0]   row_full;
  logic signed [CORDW:0]   d_full;
  logic [ADDRW-1:0]        row_base;

  // One extra bit so that widely separated coordinates cannot wrap into range.
  assign row_full = {sy[CORDW-1], sy} - {spr_y_reg[CORDW-1], spr_y_reg};
  assign d_full   = {sx[CORDW-1], sx} - {spr_x_reg[CORDW-1], spr_x_reg};
  assign row_base = ADDRW'(row_full) * ADDRW'(SPR_WIDTH);
  assign rd_pix   = row_buf[rd_idx];

  always_comb begin
    state_next    = state_reg;
    spr_x_next    = spr_x_reg;
    spr_y_next    = spr_y_reg;
    rom_addr_next = rom_addr_reg;
    cnt_next      = cnt_reg;
    index_next    = index_reg;
    pix_next      = '0;
    drawing_next  = 1'b0;
    cap_en        = 1'b0;
    cap_idx       = IDXW'(cnt_reg - CNTW'(1));
    rd_idx        = index_reg;
    emit          = 1'b0;

    if (line) begin
      spr_x_next = spr_x;
      spr_y_next = spr_y;
      state_next = REG_POS;
    end else begin
      case (state_reg)
        REG_POS: begin
          if (!row_full[CORDW] && (row_full < ROW_LIM)) begin
            state_next    = FETCH;
            cnt_next      = '0;
            rom_addr_next = row_base;
          end else begin
            state_next = IDLE;
          end
        end
        FETCH: begin
          // Cycle k issues column k and captures column k-1 returned by the ROM.
          cap_en = (cnt_reg != '0);
          if (cnt_reg < CNT_ISSUE_LAST) rom_addr_next = rom_addr_reg + ADDRW'(1);
          if (cnt_reg == CNT_LAST) state_next = WAIT_POS;
          else cnt_next = cnt_reg + CNTW'(1);
        end
        WAIT_POS: begin
          // First visible pixel is emitted here so the output lands one cycle after sx.
          if (!d_full[CORDW] && (d_full < COL_LIM)) begin
            state_next = DRAW;
            index_next = IDXW'(d_full);
            rd_idx     = IDXW'(d_full);
            emit       = 1'b1;
          end else if (!d_full[CORDW]) begin
            state_next = IDLE;
          end
        end
        DRAW: begin
          if (index_reg == IDX_LAST) begin
            state_next = IDLE;
          end else begin
            index_next = index_reg + IDXW'(1);
            rd_idx     = index_reg + IDXW'(1);
            emit       = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (emit) begin
`ifdef SPRITE_TRANSPARENT_EN
      drawing_next = (rd_pix != '0);
      pix_next     = rd_pix;
`else
      drawing_next = 1'b1;
      pix_next     = rd_pix;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      spr_x_reg    <= '0;
      spr_y_reg    <= '0;
      rom_addr_reg <= '0;
      cnt_reg      <= '0;
      index_reg    <= '0;
      pix_reg      <= '0;
      drawing_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      spr_x_reg    <= spr_x_next;
      spr_y_reg    <= spr_y_next;
      rom_addr_reg <= rom_addr_next;
      cnt_reg      <= cnt_next;
      index_reg    <= index_next;
      pix_reg      <= pix_next;
      drawing_reg  <= drawing_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SPR_WIDTH; i++) row_buf[i] <= '0;
    end else if (cap_en) begin
      row_buf[cap_idx] <= rom_data;
    end
  end

  assign rom_addr = rom_addr_reg;
  assign pix      = pix_reg;
  assign drawing  = drawing_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_sprite_line_drawer.sv
// Directed bench for sprite_line_drawer with a synchronous ROM model holding ROM[a] = a & 0xF.
module tb_sprite_line_drawer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CB = 4;
  localparam int CW = 16;
  localparam int AW = 6;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 line;
  logic signed [CW-1:0] sx, sy, spr_x, spr_y;
  logic [AW-1:0]        rom_addr;
  logic [CB-1:0]        rom_data;
  logic [CB-1:0]        pix;
  logic                 drawing;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  sprite_line_drawer #(
    .SPR_WIDTH(W), .SPR_HEIGHT(H), .COLR_BITS(CB), .CORDW(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .line(line),
    .sx(sx), .sy(sy), .spr_x(spr_x), .spr_y(spr_y),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix(pix), .drawing(drawing), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom_addr[3:0];

  typedef struct {
    int spr_x;
    int spr_y;
    int sy;
    int sx_hold;
    int sx_start;
    int fetch;
    int base;
    int ndraw;
    int first_sx;
    int first_pix;
  } vec_t;

  vec_t vecs[8];
  vec_t rp;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int addr0;
    int nd;
    addr0   = int'(rom_addr);
    spr_x   = CW'(v.spr_x);
    spr_y   = CW'(v.spr_y);
    sy      = CW'(v.sy);
    sx      = CW'(v.sx_hold);
    line    = 1'b1;
    step();
    line    = 1'b0;
    check("busy_regpos", int'(busy), 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (v.fetch != 0) begin
        if (k <= W) check("fetch_addr", int'(rom_addr), v.base + k - 1);
        else        check("addr_hold", int'(rom_addr), v.base + W - 1);
      end else begin
        check("nofetch_addr", int'(rom_addr), addr0);
        check("nofetch_busy", int'(busy), 0);
      end
    end
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      sx = CW'(v.sx_start + i);
      step();
      if (drawing) begin
        check("draw_sx", v.sx_start + i, v.first_sx + nd);
        check("draw_pix", int'(pix), v.first_pix + nd);
        nd++;
      end else begin
        check("idle_pix", int'(pix), 0);
      end
    end
    check("draw_count", nd, v.ndraw);
    check("busy_end", int'(busy), 0);
    $display("vec %0d: spr=(%0d,%0d) sy=%0d drawn=%0d expected=%0d", id, v.spr_x, v.spr_y, v.sy, nd, v.ndraw);
  endtask

  initial begin
    vecs[0] = '{100, 10, 13,   0,  80, 1, 24, 8, 100, 8};
    vecs[1] = '{100, 10,  9,   0,  80, 0,  0, 0,   0, 0};
    vecs[2] = '{100, 10, 18,   0,  80, 0,  0, 0,   0, 0};
    vecs[3] = '{ -3,  0,  0, -50,   0, 1,  0, 5,   0, 3};
`ifdef SPRITE_TRANSPARENT_EN
    vecs[4] = '{ 20,  5,  7,   0,  10, 1, 16, 7,  21, 1};
    rp      = '{100, 10, 14,   0,  80, 1, 32, 7, 101, 1};
`else
    vecs[4] = '{ 20,  5,  7,   0,  10, 1, 16, 8,  20, 0};
    rp      = '{100, 10, 14,   0,  80, 1, 32, 8, 100, 0};
`endif
    vecs[5] = '{ 50, 10, 17,   0,  40, 1, 56, 8,  50, 8};
    vecs[6] = '{  5, 10, 10, 100, 100, 1,  0, 0,   0, 0};
    vecs[7] = '{ 10, 10, 10,   0,  14, 1,  0, 4,  14, 4};

    reset_n = 1'b0;
    line    = 1'b0;
    sx      = '0;
    sy      = '0;
    spr_x   = '0;
    spr_y   = '0;
    #12;
    check("rst_pix", int'(pix), 0);
    check("rst_drawing", int'(drawing), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_addr", int'(rom_addr), 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    $display("reset: pix=%0d drawing=%0d busy=%0d addr=%0d", pix, drawing, busy, rom_addr);

    for (int n = 0; n < 8; n++) run_vec(n, vecs[n]);

    // Restart during fetch: row 3 fetch aborted, row 4 must replace it entirely.
    spr_x = CW'(100);
    spr_y = CW'(10);
    sy    = CW'(13);
    sx    = '0;
    line  = 1'b1;
    step();
    line  = 1'b0;
    step();
    step();
    step();
    check("refetch_mid_addr", int'(rom_addr), 26);
    run_vec(8, rp);

    // Asynchronous reset in the middle of a draw.
    begin
      bit found;
      int s;
      found = 1'b0;
      spr_x = CW'(100);
      spr_y = CW'(10);
      sy    = CW'(13);
      sx    = '0;
      line  = 1'b1;
      step();
      line  = 1'b0;
      for (int k = 0; k < 10; k++) step();
      s = 90;
      for (int i = 0; i < 40 && !found; i++) begin
        sx = CW'(s);
        s++;
        step();
        if (drawing) found = 1'b1;
      end
      check("rst_found_draw", int'(found), 1);
      sx = CW'(s);
      s++;
      step();
      #2 reset_n = 1'b0;
      #1;
      check("arst_pix", int'(pix), 0);
      check("arst_drawing", int'(drawing), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_addr", int'(rom_addr), 0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
        sx = CW'(s);
        s++;
        step();
        check("post_rst_drawing", int'(drawing), 0);
        check("post_rst_busy", int'(busy), 0);
      end
      $display("async reset mid-draw: found=%0d drawing=%0d busy=%0d", found, drawing, busy);
    end

    run_vec(9, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
